pe_seq_ctrl: RTL
================

// Module: pe_seq_ctrl
// PURPOSE
//  Per-PE sequencer sitting directly upstream of one PE: accepts weight/activation/psum streams
//  over valid/ready, drives the PE load/start/sums strobes, and collects the PE's systolic psum
//  output into a small output FIFO. One job = load W weights, load A acts, compute, drain A+1-W psums.
// PARAMETERS
//  dataSize    8   weight/activation width (signed)
//  macResSize  20  psum width (signed), = 2*dataSize+4
//  wSpadNReg   16  max legal cfg_wcount
//  aSpadNReg   16  max legal cfg_acount
//  TIMEOUT     4096 watchdog limit in cycles (used only with PE_SEQ_TIMEOUT_EN)
// PORTS
//  clk            in  1           clock
//  nrst           in  1           async active-low reset
//  cfg_wcount     in  8           weights per job; sampled on accepted cfg_go
//  cfg_acount     in  8           activations per job; sampled on accepted cfg_go
//  cfg_go         in  1           start job (accepted only in IDLE)
//  busy_o         out 1           high in every state except IDLE
//  done_o         out 1           1-cycle pulse when job completes
//  err_o          out 1           1-cycle pulse on rejected config or timeout
//  w_data_i/w_valid_i/w_ready_o   in dataSize / in 1 / out 1   weight stream
//  a_data_i/a_valid_i/a_ready_o   in dataSize / in 1 / out 1   activation stream
//  p_data_i/p_valid_i/p_ready_o   in macResSize / in 1 / out 1 incoming psum stream (from PE above)
//  o_data_o/o_valid_o/o_ready_i   out macResSize / out 1 / in 1 outgoing psum stream
//  pe_weights_o   out dataSize    to PE weights_i
//  pe_acts_o      out dataSize    to PE acts_i
//  pe_psum_o      out macResSize  to PE psum_i
//  pe_psum_i      in  macResSize  from PE psum_o
//  pe_loadw_o, pe_loada_o, pe_start_o, pe_sums_o  out 1  PE ctrl strobes
//  pe_wcount_o, pe_acount_o  out 8  latched job counts to PE
//  pe_done_i      in  1           PE flag_done
// BEHAVIOUR
//  Reset (async, nrst=0): FSM->IDLE; all outputs 0; FIFO emptied; counters 0. Reset mid-job aborts it.
//  States: IDLE -> LOADW -> SETW -> LOADA -> SETA -> START -> WAIT -> DRAIN -> FLUSH -> IDLE.
//  IDLE: cfg_go with 1<=W<=wSpadNReg, 1<=A<=aSpadNReg, W<=A -> latch counts, LOADW; else err_o pulse, stay.
//  LOADW: w_ready_o=1 while wcnt<W. Each handshake registers data: pe_weights_o<=w_data_i,
//   pe_loadw_o<=1 next cycle (1-cycle latency); no handshake -> pe_loadw_o=0. After W-th handshake -> SETW.
//  SETW/SETA: 2 idle cycles (final strobe lands, then >=1 cycle with all strobes low).
//  LOADA: same as LOADW using a_* / pe_acts_o / pe_loada_o, A handshakes, -> SETA -> START.
//  START: pe_start_o=1 for exactly 1 cycle -> WAIT. WAIT: hold until pe_done_i=1 -> DRAIN.
//  DRAIN: N=A+1-W psums. Issue when p_valid_i && (fifo_cnt+inflight)<2: p_ready_o=1,
//   pe_psum_o<=p_data_i, pe_sums_o=1 next cycle. pe_psum_i captured into FIFO exactly 1 cycle
//   after each pe_sums_o cycle. After N-th issue -> FLUSH.
//  FLUSH: wait until FIFO empty and no inflight; done_o pulse; -> IDLE.
//  Output FIFO: depth 2, FWFT; o_valid_o=!empty; pop on o_valid_o&&o_ready_i; simultaneous push+pop
//   keeps count. Credit rule guarantees no overflow; pe_sums_o never asserted without a free slot.
//  Arithmetic: no arithmetic on data; N computed in 8 bits (W<=A guarantees no underflow).
//  cfg_go outside IDLE ignored (no err). Input valids outside their phase: ready stays 0.
//  Edge: W==A -> N=1. Back-to-back jobs: cfg_go accepted the cycle after done_o.
// CONFIGURATION
//  PE_SEQ_TIMEOUT_EN defined: cycle counter in WAIT; reaching TIMEOUT without pe_done_i ->
//   err_o pulse, all strobes 0, FIFO cleared, -> IDLE (no done_o).
//  Undefined: WAIT holds indefinitely; err_o only for rejected config.
// TESTING
//  W=3,A=16, streams always valid, o_ready_i=1 -> 3 pe_loadw_o, 16 pe_loada_o, 1 pe_start_o, 14 outputs, done_o.
//  Same job, w_valid_i toggles 1/0 -> pe_loadw_o high exactly 3 cycles, weights in order.
//  o_ready_i=0 during DRAIN -> pe_sums_o stops after 2 issues, o_data_o holds first psum; resume -> 14 total, order kept.
//  cfg_go with W=5,A=4; W=0; A=17 -> err_o pulse each, busy_o stays 0.
//  nrst low during DRAIN -> all outputs 0 immediately, FIFO empty; new W=3,A=3 job gives 1 output.
//  PE_SEQ_TIMEOUT_EN, TIMEOUT=64, pe_done_i held 0 -> err_o at cycle 64 in WAIT, back to IDLE.

Source files
------------

// File: rtl/pe_seq_ctrl.sv
// Per-PE sequencer: streams weights/acts into one PE, fires start, then feeds psums through it into a 2-entry FWFT FIFO.
// Optional WAIT-state watchdog enabled by defining PE_SEQ_TIMEOUT_EN.
module pe_seq_ctrl #(
    parameter int dataSize   = 8,
    parameter int macResSize = 20,
    parameter int wSpadNReg  = 16,
    parameter int aSpadNReg  = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [7:0]            cfg_wcount,
    input  logic [7:0]            cfg_acount,
    input  logic                  cfg_go,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    input  logic [dataSize-1:0]   w_data_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic [dataSize-1:0]   a_data_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [macResSize-1:0] p_data_i,
    input  logic                  p_valid_i,
    output logic                  p_ready_o,
    output logic [macResSize-1:0] o_data_o,
    output logic                  o_valid_o,
    input  logic                  o_ready_i,
    output logic [dataSize-1:0]   pe_weights_o,
    output logic [dataSize-1:0]   pe_acts_o,
    output logic [macResSize-1:0] pe_psum_o,
    input  logic [macResSize-1:0] pe_psum_i,
    output logic                  pe_loadw_o,
    output logic                  pe_loada_o,
    output logic                  pe_start_o,
    output logic                  pe_sums_o,
    output logic [7:0]            pe_wcount_o,
    output logic [7:0]            pe_acount_o,
    input  logic                  pe_done_i
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_LOADW, ST_SETW, ST_LOADA, ST_SETA,
        ST_START, ST_WAIT, ST_DRAIN, ST_FLUSH
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            wcount_q, wcount_d, acount_q, acount_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [dataSize-1:0]   weights_q, weights_d, acts_q, acts_d;
    logic [macResSize-1:0] psum_q, psum_d;
    logic                  loadw_q, loadw_d, loada_q, loada_d;
    logic                  sums_q, sums_d, cap_q, cap_d;
    logic                  done_q, done_d, err_q, err_d;
    logic [macResSize-1:0] mem_q [2];
    logic [macResSize-1:0] mem_d [2];
    logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;
    logic                  fifo_clear, push, pop;
    logic                  w_hs, a_hs, p_hs, cfg_ok, credit_ok;
    logic [2:0]            occupancy;
    logic [7:0]            n_psums;
`ifdef PE_SEQ_TIMEOUT_EN
    localparam int TmoW = $clog2(TIMEOUT + 1);
    logic [TmoW-1:0]       tmo_q, tmo_d;
`endif

    // A psum slot is reserved from issue until its PE result lands in the FIFO.
    assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, sums_q} + {2'b00, cap_q};
    assign credit_ok = occupancy < 3'd2;
    assign n_psums   = acount_q - wcount_q + 8'd1;
    assign cfg_ok    = (cfg_wcount >= 8'd1) && (cfg_wcount <= 8'(wSpadNReg)) &&
                       (cfg_acount >= 8'd1) && (cfg_acount <= 8'(aSpadNReg)) &&
                       (cfg_wcount <= cfg_acount);

    assign busy_o       = state_q != ST_IDLE;
    assign w_ready_o    = (state_q == ST_LOADW) && (cnt_q < wcount_q);
    assign a_ready_o    = (state_q == ST_LOADA) && (cnt_q < acount_q);
    assign p_ready_o    = (state_q == ST_DRAIN) && credit_ok;
    assign pe_start_o   = state_q == ST_START;
    assign w_hs         = w_valid_i && w_ready_o;
    assign a_hs         = a_valid_i && a_ready_o;
    assign p_hs         = p_valid_i && p_ready_o;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign pe_weights_o = weights_q;
    assign pe_acts_o    = acts_q;
    assign pe_psum_o    = psum_q;
    assign pe_loadw_o   = loadw_q;
    assign pe_loada_o   = loada_q;
    assign pe_sums_o    = sums_q;
    assign pe_wcount_o  = wcount_q;
    assign pe_acount_o  = acount_q;
    assign o_valid_o    = fifo_cnt_q != 2'd0;
    assign o_data_o     = mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        wcount_d   = wcount_q;
        acount_d   = acount_q;
        cnt_d      = cnt_q;
        weights_d  = weights_q;
        acts_d     = acts_q;
        psum_d     = psum_q;
        loadw_d    = 1'b0;
        loada_d    = 1'b0;
        sums_d     = 1'b0;
        cap_d      = sums_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        fifo_clear = 1'b0;
`ifdef PE_SEQ_TIMEOUT_EN
        tmo_d      = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cfg_go) begin
                    if (cfg_ok) begin
                        wcount_d = cfg_wcount;
                        acount_d = cfg_acount;
                        cnt_d    = 8'd0;
                        state_d  = ST_LOADW;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOADW: begin
                if (w_hs) begin
                    weights_d = w_data_i;
                    loadw_d   = 1'b1;
                    if (cnt_q + 8'd1 == wcount_q) begin
                        cnt_d   = 8'd0;
                        state_d = ST_SETW;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_SETW, ST_SETA: begin
                // Two settle cycles: the last load strobe lands, then one fully quiet cycle.
                if (cnt_q == 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = (state_q == ST_SETW) ? ST_LOADA : ST_START;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_LOADA: begin
                if (a_hs) begin
                    acts_d  = a_data_i;
                    loada_d = 1'b1;
                    if (cnt_q + 8'd1 == acount_q) begin
                        cnt_d   = 8'd0;
                        state_d = ST_SETA;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (pe_done_i) begin
                    cnt_d   = 8'd0;
                    state_d = ST_DRAIN;
                end
`ifdef PE_SEQ_TIMEOUT_EN
                else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    fifo_clear = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_DRAIN: begin
                if (p_hs) begin
                    psum_d = p_data_i;
                    sums_d = 1'b1;
                    if (cnt_q + 8'd1 == n_psums) begin
                        cnt_d   = 8'd0;
                        state_d = ST_FLUSH;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_FLUSH: begin
                if ((fifo_cnt_q == 2'd0) && !sums_q && !cap_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output FIFO: PE result is pushed the cycle after its sums strobe.
    always_comb begin
        push       = cap_q;
        pop        = o_valid_o && o_ready_i;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = pe_psum_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 2'd1;
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - 2'd1;
        end
        if (fifo_clear) begin
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            fifo_cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            wcount_q   <= '0;
            acount_q   <= '0;
            cnt_q      <= '0;
            weights_q  <= '0;
            acts_q     <= '0;
            psum_q     <= '0;
            loadw_q    <= 1'b0;
            loada_q    <= 1'b0;
            sums_q     <= 1'b0;
            cap_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
`ifdef PE_SEQ_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wcount_q   <= wcount_d;
            acount_q   <= acount_d;
            cnt_q      <= cnt_d;
            weights_q  <= weights_d;
            acts_q     <= acts_d;
            psum_q     <= psum_d;
            loadw_q    <= loadw_d;
            loada_q    <= loada_d;
            sums_q     <= sums_d;
            cap_q      <= cap_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
`ifdef PE_SEQ_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

endmodule
